// File: rtl/reset_stream_source.sv
// Source-domain writer for the reset-crossing bit FIFO: merges and rate-limits
// reset requests into single-bit writes, stretches a local reset copy and counts writes.
//
// state      | meaning
// -----------+----------------------------------------------------------------
// ST_IDLE    | nothing outstanding; a req moves to ST_ISSUE
// ST_ISSUE   | write outstanding; fires when the FIFO is not full, further reqs merge
// ST_HOLDOFF | fixed quiet window after a write; reqs collapse into the pending flag
module reset_stream_source #(
    parameter int STRETCH_CYCLES = 4,
    parameter int HOLDOFF_CYCLES = 16,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic                 fifo_din,
    output logic                 local_reset,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] issued_count
);

    localparam int HOLD_W    = $clog2(HOLDOFF_CYCLES + 1);
    localparam int STRETCH_W = $clog2(STRETCH_CYCLES + 1);

    localparam logic [HOLD_W-1:0]    HOLD_LOAD    = HOLD_W'(HOLDOFF_CYCLES - 1);
    localparam logic [STRETCH_W-1:0] STRETCH_LOAD = STRETCH_W'(STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic                   pending_q, pending_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [STRETCH_W-1:0]   stretch_cnt_q, stretch_cnt_d;
    logic                   local_reset_q, local_reset_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   commit;

    assign commit = (state_q == ST_ISSUE) && !fifo_full;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        hold_cnt_d = hold_cnt_q;
        count_d    = count_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (commit) begin
                    state_d    = ST_HOLDOFF;
                    hold_cnt_d = HOLD_LOAD;
                    count_d    = count_q + 1'b1;
                end
            end
            ST_HOLDOFF: begin
                // A req on the terminal edge still counts toward the next write.
                if (hold_cnt_q == '0) begin
                    state_d   = (pending_q || req) ? ST_ISSUE : ST_IDLE;
                    pending_d = 1'b0;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                    if (req) begin
                        pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase
    end

    // A commit while the pulse is still running reloads it, keeping local_reset contiguous.
    always_comb begin
        stretch_cnt_d = stretch_cnt_q;
        local_reset_d = 1'b0;
        if (commit) begin
            stretch_cnt_d = STRETCH_LOAD;
            local_reset_d = 1'b1;
        end else if (stretch_cnt_q != '0) begin
            stretch_cnt_d = stretch_cnt_q - 1'b1;
            local_reset_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pending_q     <= 1'b0;
            hold_cnt_q    <= '0;
            stretch_cnt_q <= '0;
            local_reset_q <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            hold_cnt_q    <= hold_cnt_d;
            stretch_cnt_q <= stretch_cnt_d;
            local_reset_q <= local_reset_d;
            count_q       <= count_d;
        end
    end

    assign fifo_wr_en   = commit;
    assign fifo_din     = commit;
    assign local_reset  = local_reset_q;
    assign busy         = (state_q != ST_IDLE) || pending_q;
    assign issued_count = count_q;

endmodule

// File: tb/tb_reset_stream_source.sv
// Bench for reset_stream_source: two instances (default and small/wrapping parameters)
// share stimulus and are checked every cycle against a time-window reference model.
module tb_reset_stream_source;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req = 1'b0;
    logic fifo_full = 1'b0;

    logic       wr_a, din_a, lr_a, busy_a;
    logic [7:0] cnt_a;
    logic       wr_b, din_b, lr_b, busy_b;
    logic [1:0] cnt_b;

    reset_stream_source dut_a (
        .clk(clk), .rst(rst), .req(req), .fifo_full(fifo_full),
        .fifo_wr_en(wr_a), .fifo_din(din_a), .local_reset(lr_a),
        .busy(busy_a), .issued_count(cnt_a)
    );

    reset_stream_source #(
        .STRETCH_CYCLES(6), .HOLDOFF_CYCLES(3), .CNT_WIDTH(2)
    ) dut_b (
        .clk(clk), .rst(rst), .req(req), .fifo_full(fifo_full),
        .fifo_wr_en(wr_b), .fifo_din(din_b), .local_reset(lr_b),
        .busy(busy_b), .issued_count(cnt_b)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int hold_p[2] = '{16, 3};
    int str_p[2]  = '{4, 6};
    int cw_p[2]   = '{8, 2};

    // Model: a write happens in any cycle with an outstanding request and FIFO not full;
    // the quiet window and the local_reset pulse are windows measured from the last write.
    int t = 0;
    bit outst[2]  = '{1'b0, 1'b0};
    bit pend[2]   = '{1'b0, 1'b0};
    bit have_w[2] = '{1'b0, 1'b0};
    int last_w[2] = '{0, 0};
    int nwr[2]    = '{0, 0};
    int wr_seen_a = 0;
    int wr_seen_b = 0;

    task automatic check(input string tag, input int i, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, i, t, got, exp);
        end
    endtask

    task automatic step(input logic r_req, input logic r_full, input logic r_rst);
        bit         in_hold, e_wr, e_lr, e_busy;
        logic [7:0] e_cnt;
        logic       g_wr, g_din, g_lr, g_busy;
        logic [7:0] g_cnt;
        @(posedge clk);
        #1;
        req       = r_req;
        fifo_full = r_full;
        rst       = r_rst;
        #3;
        wr_seen_a += (wr_a === 1'b1) ? 1 : 0;
        wr_seen_b += (wr_b === 1'b1) ? 1 : 0;
        for (int i = 0; i < 2; i++) begin
            in_hold = have_w[i] && (t > last_w[i]) && (t <= last_w[i] + hold_p[i]);
            e_lr    = have_w[i] && (t > last_w[i]) && (t <= last_w[i] + str_p[i]);
            e_wr    = outst[i] && !r_full;
            e_busy  = outst[i] || in_hold || pend[i];
            e_cnt   = 8'(nwr[i] % (1 << cw_p[i]));
            g_wr    = (i == 0) ? wr_a   : wr_b;
            g_din   = (i == 0) ? din_a  : din_b;
            g_lr    = (i == 0) ? lr_a   : lr_b;
            g_busy  = (i == 0) ? busy_a : busy_b;
            g_cnt   = (i == 0) ? cnt_a  : {6'b0, cnt_b};
            check("wr_en",        i, {7'b0, g_wr},   {7'b0, e_wr});
            check("din",          i, {7'b0, g_din},  {7'b0, e_wr});
            check("local_reset",  i, {7'b0, g_lr},   {7'b0, e_lr});
            check("busy",         i, {7'b0, g_busy}, {7'b0, e_busy});
            check("issued_count", i, g_cnt,          e_cnt);

            if (r_rst) begin
                outst[i]  = 1'b0;
                pend[i]   = 1'b0;
                have_w[i] = 1'b0;
                nwr[i]    = 0;
            end else if (e_wr) begin
                nwr[i]    = nwr[i] + 1;
                last_w[i] = t;
                have_w[i] = 1'b1;
                outst[i]  = 1'b0;
            end else if (outst[i]) begin
                outst[i] = 1'b1;
            end else if (in_hold) begin
                if (r_req) pend[i] = 1'b1;
                if (t == last_w[i] + hold_p[i]) begin
                    outst[i] = pend[i];
                    pend[i]  = 1'b0;
                end
            end else if (r_req) begin
                outst[i] = 1'b1;
            end
        end
        t++;
    endtask

    task automatic run(input int n, input logic r_req, input logic r_full);
        for (int k = 0; k < n; k++) step(r_req, r_full, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
    endtask

    int wrap_exp[5] = '{1, 2, 3, 0, 1};

    initial begin
        do_reset();
        run(5, 1'b0, 1'b0);

        // single pulse
        wr_seen_a = 0;
        step(1'b1, 1'b0, 1'b0);
        run(30, 1'b0, 1'b0);
        check("single_writes", 0, 8'(wr_seen_a), 8'd1);
        check("single_count",  0, cnt_a, 8'd1);
        check("single_idle",   0, {7'b0, busy_a}, 8'd0);

        // backpressure: FIFO full for ten cycles after the request
        do_reset();
        wr_seen_a = 0;
        step(1'b1, 1'b0, 1'b0);
        run(10, 1'b0, 1'b1);
        check("bp_no_write", 0, 8'(wr_seen_a), 8'd0);
        run(30, 1'b0, 1'b0);
        check("bp_writes", 0, 8'(wr_seen_a), 8'd1);
        check("bp_count",  0, cnt_a, 8'd1);

        // merge: reqs at offsets 0, 1, 4, 10
        do_reset();
        wr_seen_a = 0;
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(40, 1'b0, 1'b0);
        check("merge_writes", 0, 8'(wr_seen_a), 8'd2);
        check("merge_count",  0, cnt_a, 8'd2);

        // level request held for 100 cycles
        do_reset();
        run(100, 1'b1, 1'b0);
        run(40, 1'b0, 1'b0);

        // reset during HOLDOFF with a pending request
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        wr_seen_a = 0;
        run(40, 1'b0, 1'b0);
        check("rst_no_write", 0, 8'(wr_seen_a), 8'd0);
        check("rst_count",    0, cnt_a, 8'd0);

        // counter wrap on the 2-bit instance
        do_reset();
        for (int r = 0; r < 5; r++) begin
            step(1'b1, 1'b0, 1'b0);
            run(19, 1'b0, 1'b0);
            check("wrap_count", 1, {6'b0, cnt_b}, 8'(wrap_exp[r]));
        end

        // randomized traffic with occasional resets and level bursts
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic r_req, r_full, r_rst;
            if ((k / 64) % 4 == 3) r_req = ($urandom_range(0, 7) != 0);
            else                   r_req = ($urandom_range(0, 9) == 0);
            r_full = ($urandom_range(0, 3) == 0) || (((k / 50) % 7) == 5);
            r_rst  = ($urandom_range(0, 399) == 0);
            step(r_req, r_full, r_rst);
        end
        run(30, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_stream_source.md
Name: reset_stream_source

Overview:
Write-side companion to the reset-crossing bit FIFO. It runs in the source clock domain. It turns local reset requests (pulse or level) into single-bit writes on the FIFO write port, which the far-domain reader turns back into a reset pulse. Requests are merged and rate-limited so the FIFO never floods. The block also holds off on FIFO full, stretches a local reset copy, and counts issued resets.

Parameters:
STRETCH_CYCLES, 4, length in cycles of local_reset pulse per issued write (>=1)
HOLDOFF_CYCLES, 16, minimum cycles spent in HOLDOFF after each FIFO write (>=1)
CNT_WIDTH, 8, width of issued_count

Ports:
clk  input  1  source-domain clock; the only clock
rst  input  1  synchronous, active-high reset
req  input  1  reset request; sampled every edge; level or pulse
fifo_full  input  1  write-side full flag of the bit FIFO
fifo_wr_en  output  1  FIFO write enable
fifo_din  output  1  FIFO write data; always equal to fifo_wr_en
local_reset  output  1  stretched reset for source-domain logic, registered
busy  output  1  high when state != IDLE or pending set
issued_count  output  CNT_WIDTH  number of FIFO writes performed, wraps mod 2^CNT_WIDTH

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; ports named clk and rst.
- State machine states are IDLE, ISSUE and HOLDOFF. There is also a pending flag (1 bit), a holdoff counter and a stretch counter.
- On rst high at an edge: state=IDLE, pending=0, counters=0, issued_count=0, local_reset=0.
  - fifo_wr_en=0 while in IDLE.
  - rst overrides all other events in the same cycle, including mid-ISSUE and mid-HOLDOFF. An interrupted write is dropped; no partial count.
- fifo_wr_en is combinational: (state==ISSUE) && !fifo_full. fifo_din mirrors fifo_wr_en.
- IDLE: req high at edge k -> ISSUE from cycle k+1.
- ISSUE:
  - If fifo_full is low during the cycle, the write occurs that cycle.
  - At the following edge: state -> HOLDOFF, holdoff counter = HOLDOFF_CYCLES-1, issued_count += 1, stretch counter loaded.
  - If fifo_full is high: stay in ISSUE, wr_en=0, no count change. The wait is unbounded.
  - req seen while in ISSUE merges into the outstanding write; it does not set pending.
- HOLDOFF:
  - Lasts exactly HOLDOFF_CYCLES cycles; the counter decrements each edge.
  - req high on any edge while in HOLDOFF sets pending; multiple requests collapse into one.
  - On the last HOLDOFF cycle, if pending (including a req on that same edge): -> ISSUE and clear pending. Otherwise -> IDLE.
- local_reset:
  - Goes high on the edge that commits a write and stays high for STRETCH_CYCLES cycles.
  - A new write while still high reloads the count, giving a contiguous pulse.
- Latency: req at edge k with FIFO not full -> wr_en high in cycle k+1 -> local_reset high cycles k+2 .. k+1+STRETCH_CYCLES -> back in IDLE at edge k+2+HOLDOFF_CYCLES if no pending request.
- Write rate: back-to-back writes are separated by at least HOLDOFF_CYCLES+1 cycles.
- A level req held high produces one write per HOLDOFF_CYCLES+1 cycles.
- issued_count wraps from 2^CNT_WIDTH-1 to 0 without a flag.

Test Plan:
- Single pulse, full=0, defaults: req high one cycle at edge 10 -> wr_en=din=1 in cycle 11 only; local_reset high cycles 12-15; busy low again from edge 28; issued_count=1.
- Backpressure: full=1 for cycles 11-20, req at edge 10 -> wr_en=0 through cycle 20, single write in cycle 21, count=1, no duplicate write.
- Merge: req pulses at cycles 11, 14 and 20, during ISSUE and HOLDOFF -> exactly 2 writes total. The second write occurs the cycle after HOLDOFF ends (cycle 28); count=2.
- Level req held 100 cycles with defaults -> writes spaced exactly 17 cycles apart; local_reset is a sequence of 4-cycle pulses.
- Reset mid-operation: rst at edge during HOLDOFF with pending=1 -> next cycle IDLE, busy=0, count=0, local_reset=0, no further writes.
- Wrap: CNT_WIDTH=2, 5 spaced requests -> issued_count sequence 1,2,3,0,1.
